// File: rtl/saradc_pkg.sv
// Shared types and constants for the SAR ADC sequencing controller.
// No logic; widths here bound the averaging range and accumulator size.
// No flow control of its own.
package saradc_pkg;

  localparam int ADC_W              = 10;
  localparam int AVG_MAX_LOG2       = 7;
  localparam int ACC_W              = 17;
  localparam int AVG_W              = 3;
  localparam int CNT_W              = AVG_MAX_LOG2 + 1;
  localparam int IVL_W              = 16;
  localparam int TIMEOUT_CYCLES_DEF = 4095;
  localparam int EN_LOW_CYCLES_DEF  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAL_REQ,
    S_CONV_REQ,
    S_ACCUM,
    S_EN_GAP,
    S_PUBLISH,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [AVG_W-1:0] avg_log2;
    logic [IVL_W-1:0] interval;
  } cfg_t;

  function automatic logic [CNT_W-1:0] batch_size(input logic [AVG_W-1:0] log2);
    batch_size = CNT_W'(1) << log2;
  endfunction

endpackage

// File: rtl/saradc_valid_sync.sv
// Brings the macro's asynchronous valid strobe into the clock domain and emits a one-cycle completion pulse.
// Latency: pulse appears 3 cycles after adc_valid rises (2 sync flops + edge register).
// No backpressure; a completion is a single-cycle event.
module saradc_valid_sync (
  input  logic clk,
  input  logic rst,
  input  logic adc_valid,
  output logic cvt_done
);

  logic sync1, sync2, sync2_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync2_d  <= 1'b0;
      cvt_done <= 1'b0;
    end else begin
      sync1    <= adc_valid;
      sync2    <= sync1;
      sync2_d  <= sync2;
      cvt_done <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/saradc_ctrl.sv
// Sequences calibration/conversion requests to the SAR ADC macro and averages 2^N results per batch.
// Latency: per conversion 1 + EN_LOW_CYCLES + 3 sync cycles plus macro time; data_valid rises the cycle after PUBLISH.
// Output is a single register: an unread result is overwritten on the next batch and flagged as overrun.
module saradc_ctrl
  import saradc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int EN_LOW_CYCLES  = EN_LOW_CYCLES_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             continuous,
  input  logic             cal_req,
  input  logic [AVG_W-1:0] avg_log2,
  input  logic [IVL_W-1:0] interval,
  input  logic             clr_err,
  output logic             adc_en,
  output logic             adc_cal,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_result,
  output logic [ADC_W-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(EN_LOW_CYCLES + 1);

  state_t           state, state_nxt;
  cfg_t             cfg;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] samp_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [IVL_W-1:0] int_cnt;
  logic             cvt_done;
  logic             tmo_hit;
  logic             in_req;

  saradc_valid_sync u_valid_sync (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .adc_valid (adc_valid),
    .cvt_done  (cvt_done)
  );

  assign busy   = (state != S_IDLE);
  assign in_req = (state == S_CAL_REQ) || (state == S_CONV_REQ);

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = cal_req ? S_CAL_REQ : S_CONV_REQ;
      end
      S_CAL_REQ, S_CONV_REQ: begin
        // A completion arriving on the last allowed cycle still counts.
        if (cvt_done) begin
          state_nxt = (state == S_CAL_REQ) ? S_EN_GAP : S_ACCUM;
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_ACCUM: begin
        state_nxt = (samp_cnt + CNT_W'(1) == batch_size(cfg.avg_log2)) ? S_PUBLISH : S_EN_GAP;
      end
      S_EN_GAP: begin
        if (gap_cnt == GAP_W'(EN_LOW_CYCLES - 1)) state_nxt = S_CONV_REQ;
      end
      S_PUBLISH: begin
        if (!continuous)               state_nxt = S_IDLE;
        else if (cfg.interval != '0)   state_nxt = S_WAIT;
        else                           state_nxt = S_EN_GAP;
      end
      S_WAIT: begin
        if (!continuous)                                state_nxt = S_IDLE;
        else if (int_cnt == cfg.interval - IVL_W'(1))   state_nxt = S_EN_GAP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      cfg         <= '0;
      acc         <= '0;
      samp_cnt    <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      int_cnt     <= '0;
      adc_en      <= 1'b0;
      adc_cal     <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      // Pins are registered from the next state so they toggle glitch-free with the FSM.
      adc_en  <= (state_nxt == S_CAL_REQ) || (state_nxt == S_CONV_REQ);
      adc_cal <= (state_nxt == S_CAL_REQ);

      if (state == S_IDLE && start) cfg <= '{avg_log2: avg_log2, interval: interval};

      tmo_cnt <= in_req              ? tmo_cnt + 1'b1 : '0;
      gap_cnt <= (state == S_EN_GAP) ? gap_cnt + 1'b1 : '0;
      int_cnt <= (state == S_WAIT)   ? int_cnt + 1'b1 : '0;

      if (state == S_ACCUM) begin
        acc      <= acc + ACC_W'(adc_result);
        samp_cnt <= samp_cnt + 1'b1;
      end else if (state == S_PUBLISH || tmo_hit) begin
        acc      <= '0;
        samp_cnt <= '0;
      end

      if (state == S_PUBLISH) begin
        data       <= ADC_W'(acc >> cfg.avg_log2);
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end

      // Error events are applied after the clear so they win a same-cycle clr_err.
      if (clr_err) overrun <= 1'b0;
      if (state == S_PUBLISH && data_valid && !data_ready) overrun <= 1'b1;

      if (clr_err) timeout_err <= 1'b0;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_saradc_ctrl.sv
// Scoreboard bench for saradc_ctrl: a behavioural ADC macro answers requests from a queue,
// expected averages are queued at stimulus time and popped by an output monitor.
module tb_saradc_ctrl;

  localparam int TMO    = 100;
  localparam int EN_LOW = 2;

  typedef struct {
    logic [9:0] val;
    logic       cal;
  } conv_t;

  logic        clk = 1'b0;
  logic        wb_rst_i, start, continuous, cal_req, clr_err;
  logic [2:0]  avg_log2;
  logic [15:0] interval;
  logic        adc_en, adc_cal, adc_valid;
  logic [9:0]  adc_result, data;
  logic        data_valid, data_ready, busy, overrun, timeout_err;

  conv_t      mac_q[$];
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int fixed_d  = 0;
  int ready_mode = 1;

  always #5 clk = ~clk;

  saradc_ctrl #(.TIMEOUT_CYCLES(TMO), .EN_LOW_CYCLES(EN_LOW)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start), .continuous(continuous),
    .cal_req(cal_req), .avg_log2(avg_log2), .interval(interval), .clr_err(clr_err),
    .adc_en(adc_en), .adc_cal(adc_cal), .adc_valid(adc_valid), .adc_result(adc_result),
    .data(data), .data_valid(data_valid), .data_ready(data_ready), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Queue one batch for the macro model and its expected average for the monitor.
  // kind: 0 random values, 1 constant base, 2 base, base+1, ...
  task automatic queue_batch(input bit cal, input int log2, input int kind, input int base);
    int    sum;
    int    v;
    conv_t c;
    sum = 0;
    if (cal) begin
      c.val = 10'h3FF; c.cal = 1'b1; mac_q.push_back(c);
    end
    for (int i = 0; i < (1 << log2); i++) begin
      case (kind)
        0:       v = int'($urandom_range(0, 1023));
        1:       v = base;
        default: v = base + i;
      endcase
      c.val = v[9:0]; c.cal = 1'b0; mac_q.push_back(c);
      sum += v;
    end
    v = sum >> log2;
    exp_q.push_back(v[9:0]);
  endtask

  // Config is scrambled right after the pulse: the DUT must use the latched copy.
  task automatic pulse_start(input bit cal, input int log2, input int ivl);
    @(posedge clk); #1;
    start = 1'b1; cal_req = cal; avg_log2 = log2[2:0]; interval = ivl[15:0];
    @(posedge clk); #1;
    start = 1'b0; cal_req = 1'($urandom); avg_log2 = 3'($urandom); interval = 16'($urandom);
  endtask

  task automatic settle(input string name, input int max);
    int n;
    n = 0;
    while ((busy || data_valid) && n < max) begin @(negedge clk); n++; end
    check({name, "_settle"}, {busy, data_valid}, 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_adc_en"}, adc_en, 0);
    check({name, "_adc_cal"}, adc_cal, 0);
    check({name, "_data"}, data, 0);
    check({name, "_data_valid"}, data_valid, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_overrun"}, overrun, 0);
    check({name, "_timeout_err"}, timeout_err, 0);
  endtask

  // Behavioural ADC macro: answers each request after a delay, drops valid when en falls.
  initial begin
    conv_t ent;
    int d, k;
    adc_valid = 1'b0; adc_result = '0;
    forever begin
      @(posedge clk); #1;
      if (adc_en && !adc_valid && mac_q.size() > 0) begin
        ent = mac_q.pop_front();
        check("adc_cal_pin", adc_cal, ent.cal);
        d = (fixed_d > 0) ? fixed_d : int'($urandom_range(4, 30));
        k = 0;
        while (k < d && adc_en) begin @(posedge clk); #1; k++; end
        if (adc_en) begin adc_result = ent.val; adc_valid = 1'b1; end
        while (adc_en) begin @(posedge clk); #1; end
        adc_valid = 1'b0;
      end
    end
  end

  initial begin
    data_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      data_ready = (ready_mode == 2) ? 1'($urandom) : (ready_mode == 1);
    end
  end

  initial begin
    logic [9:0] want;
    forever begin
      @(negedge clk);
      if (!wb_rst_i && data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out_unexpected: data 0x%0h with no result pending", data);
        end else begin
          want = exp_q.pop_front();
          check("out_data", data, want);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    bit c;
    int l;
    wb_rst_i = 1'b1; start = 1'b0; continuous = 1'b0; cal_req = 1'b0; clr_err = 1'b0;
    avg_log2 = '0; interval = '0;
    repeat (3) @(posedge clk);
    #1 wb_rst_i = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");

    // Single conversion, held output, en high duration = macro delay + 3 detect + 1.
    ready_mode = 0; fixed_d = 20;
    queue_batch(0, 0, 1, 'h155);
    pulse_start(0, 0, 0);
    n = 0;
    @(negedge clk);
    while (adc_en && n < 500) begin n++; @(negedge clk); end
    check("en_high_cycles", n, 20 + 4);
    n = 0;
    while (!data_valid && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("held_valid", data_valid, 1);
    check("held_data", data, 'h155);
    ready_mode = 1;
    settle("t1", 100);

    // Calibration followed by a 4-sample batch.
    fixed_d = 0;
    queue_batch(1, 2, 2, 100);
    pulse_start(1, 2, 0);
    settle("t2", 1000);

    // 128 full-scale samples.
    fixed_d = 4;
    queue_batch(0, 7, 1, 1023);
    pulse_start(0, 7, 0);
    settle("t3", 5000);

    // Continuous mode with consumer stalled: overrun and inter-batch gap.
    ready_mode = 0; continuous = 1'b1; fixed_d = 6;
    queue_batch(0, 0, 0, 0);
    queue_batch(0, 0, 0, 0);
    pulse_start(0, 0, 50);
    n = 0;
    while (adc_en && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (!adc_en && n < 500) begin n++; @(negedge clk); end
    check("cont_gap_cycles", n, 1 + 1 + 50 + EN_LOW);
    n = 0;
    while (!overrun && n < 300) begin @(negedge clk); n++; end
    check("overrun_set", overrun, 1);
    check("overrun_data", data, exp_q[1]);
    @(posedge clk); #1 continuous = 1'b0;
    void'(exp_q.pop_front());
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    check("overrun_cleared", overrun, 0);
    ready_mode = 1;
    settle("t4", 200);

    // No macro response: timeout.
    pulse_start(0, 0, 0);
    n = 0; seen = 0;
    @(negedge clk);
    while (adc_en && n < 300) begin n++; seen |= data_valid; @(negedge clk); end
    check("tmo_en_cycles", n, TMO);
    check("tmo_err", timeout_err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_no_valid", seen | data_valid, 0);

    // Reset during a conversion request, then a clean batch.
    fixed_d = 40;
    queue_batch(0, 0, 1, 'h2AA);
    pulse_start(0, 0, 0);
    repeat (5) @(posedge clk);
    #1 wb_rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midrst");
    exp_q.delete(); mac_q.delete();
    @(posedge clk); #1 wb_rst_i = 1'b0;
    fixed_d = 0;
    queue_batch(0, 1, 0, 0);
    pulse_start(0, 1, 0);
    settle("t6", 1000);

    // Random batches, random consumer, ignored start pulses while busy.
    ready_mode = 2;
    for (int b = 0; b < 8; b++) begin
      c = 1'($urandom);
      l = int'($urandom_range(0, 4));
      queue_batch(c, l, 0, 0);
      pulse_start(c, l, 0);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      settle("rand", 3000);
    end

    check("sb_drained", exp_q.size(), 0);
    check("final_overrun", overrun, 0);
    check("final_timeout_err", timeout_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
